// File: rtl/scr1_pipe_mprf_wbq_pkg.sv
// Shared definitions for the MPRF write-back queue.
//   SCR1_WBQ_DEPTH        default LSU FIFO depth
//   SCR1_MPRF_ADDR_WIDTH  register address width (5 for RV32I, 4 for RV32E)
//   SCR1_XLEN             data width
//   type_scr1_wbq_src_e   which source loads the MPRF output register this cycle
package scr1_pipe_mprf_wbq_pkg;

  localparam int unsigned SCR1_WBQ_DEPTH       = 2;
  localparam int unsigned SCR1_MPRF_ADDR_WIDTH = 5;
  localparam int unsigned SCR1_XLEN            = 32;

  typedef enum logic [1:0] {
    WBQ_SRC_IDLE, // nothing to write; addr/data hold
    WBQ_SRC_ALU,  // ALU write-back takes the port
    WBQ_SRC_LSU,  // live FIFO head is written
    WBQ_SRC_KILL  // stale FIFO head is discarded, port idles
  } type_scr1_wbq_src_e;

endpackage

// File: rtl/scr1_pipe_mprf.sv
// Register file storage is not part of this bundle; the write-back queue drives its write port.

// File: rtl/scr1_pipe_wbq_fifo.sv
// LSU load-return FIFO for the write-back queue.
// Holds entries {vld, kill, rd_addr, rd_data}. It provides kill-by-address for WAW
// ordering and per-entry rs1/rs2 match vectors. The match vectors cover only valid,
// un-killed entries.
// Ports:
//   i_push/_addr/_data/_kill  enqueue at tail (caller guarantees ~o_full)
//   i_pop                     dequeue head (caller guarantees ~o_empty)
//   i_kill_req/_addr          mark every valid entry with matching rd as killed
//   i_rs1/2_addr              hazard probe addresses
//   o_full/o_empty            registered occupancy flags
//   o_head_*                  head entry contents
//   o_rs1/2_match             per-entry live address match
module scr1_pipe_wbq_fifo
  import scr1_pipe_mprf_wbq_pkg::*;
#(
  parameter int unsigned DEPTH = SCR1_WBQ_DEPTH,
  parameter int unsigned AW    = SCR1_MPRF_ADDR_WIDTH,
  parameter int unsigned XLEN  = SCR1_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [AW-1:0]    i_push_addr,
  input  logic [XLEN-1:0]  i_push_data,
  input  logic             i_push_kill,
  input  logic             i_pop,
  input  logic             i_kill_req,
  input  logic [AW-1:0]    i_kill_addr,
  input  logic [AW-1:0]    i_rs1_addr,
  input  logic [AW-1:0]    i_rs2_addr,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_head_kill,
  output logic [AW-1:0]    o_head_addr,
  output logic [XLEN-1:0]  o_head_data,
  output logic [DEPTH-1:0] o_rs1_match,
  output logic [DEPTH-1:0] o_rs2_match
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_kill;
  logic [AW-1:0]   r_addr [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];

  logic [PW-1:0]   w_count;
  logic [IW-1:0]   w_widx;
  logic [IW-1:0]   w_ridx;

  // The extra pointer bit distinguishes full from empty when the indices coincide.
  assign w_count = r_wptr - r_rptr;
  assign w_widx  = r_wptr[IW-1:0];
  assign w_ridx  = r_rptr[IW-1:0];
  assign o_full  = (w_count == PW'(DEPTH));
  assign o_empty = (w_count == '0);

  assign o_head_kill = r_kill[w_ridx];
  assign o_head_addr = r_addr[w_ridx];
  assign o_head_data = r_data[w_ridx];

  always_comb begin
    o_rs1_match = '0;
    o_rs2_match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_rs1_match[i] = r_vld[i] & ~r_kill[i] & (r_addr[i] == i_rs1_addr);
      o_rs2_match[i] = r_vld[i] & ~r_kill[i] & (r_addr[i] == i_rs2_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_vld  <= '0;
      r_kill <= '0;
    end else begin
      if (i_kill_req) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (r_vld[i] && (r_addr[i] == i_kill_addr)) begin
            r_kill[i] <= 1'b1;
          end
        end
      end
      if (i_pop) begin
        r_vld[w_ridx] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      // The tail slot is never valid when a push is allowed, so a push cannot collide
      // with the kill sweep or with the pop.
      if (i_push) begin
        r_vld[w_widx]  <= 1'b1;
        r_kill[w_widx] <= i_push_kill;
        r_addr[w_widx] <= i_push_addr;
        r_data[w_widx] <= i_push_data;
        r_wptr         <= r_wptr + 1'b1;
      end
    end
  end

`ifdef SCR1_SIM_ENV
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (w_count <= PW'(DEPTH)) else $error("wbq fifo count overflow");
    end
  end
`endif

endmodule

// File: rtl/scr1_pipe_mprf_wbq.sv
// Write-back queue in front of the single MPRF write port.
// The ALU write-back is never stalled and has priority. Load returns are buffered in a
// FIFO and drain when the port is free. One registered MPRF write is issued per cycle.
// Ports:
//   exu2wbq_w_req/rd_addr/rd_data   ALU write-back (always accepted)
//   lsu2wbq_w_req/rd_addr/rd_data   load return; wbq2lsu_w_ack accepts it
//   wbq2mprf_w_req/rd_addr/rd_data  registered MPRF write
//   exu2wbq_rs1/rs2_addr            hazard probe addresses
//   wbq2exu_rs1/rs2_pend            outstanding write to the probed register
//   wbq_empty                       FIFO empty and no MPRF write in flight
module scr1_pipe_mprf_wbq
  import scr1_pipe_mprf_wbq_pkg::*;
#(
  parameter int unsigned DEPTH      = SCR1_WBQ_DEPTH,
  parameter int unsigned ADDR_WIDTH = SCR1_MPRF_ADDR_WIDTH,
  parameter int unsigned XLEN       = SCR1_XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu2wbq_w_req,
  input  logic [ADDR_WIDTH-1:0] exu2wbq_rd_addr,
  input  logic [XLEN-1:0]       exu2wbq_rd_data,
  input  logic                  lsu2wbq_w_req,
  input  logic [ADDR_WIDTH-1:0] lsu2wbq_rd_addr,
  input  logic [XLEN-1:0]       lsu2wbq_rd_data,
  output logic                  wbq2lsu_w_ack,
  output logic                  wbq2mprf_w_req,
  output logic [ADDR_WIDTH-1:0] wbq2mprf_rd_addr,
  output logic [XLEN-1:0]       wbq2mprf_rd_data,
  input  logic [ADDR_WIDTH-1:0] exu2wbq_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] exu2wbq_rs2_addr,
  output logic                  wbq2exu_rs1_pend,
  output logic                  wbq2exu_rs2_pend,
  output logic                  wbq_empty
);

  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [XLEN-1:0]       r_data;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_head_kill;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [XLEN-1:0]       w_head_data;
  logic [DEPTH-1:0]      w_rs1_match;
  logic [DEPTH-1:0]      w_rs2_match;

  logic                  w_alu_take;
  logic                  w_push;
  logic                  w_push_kill;
  logic                  w_pop;
  type_scr1_wbq_src_e    w_src;

  // Writes to x0 are architecturally void: they are acked or ignored, never queued.
  assign w_alu_take    = exu2wbq_w_req & (|exu2wbq_rd_addr);
  assign wbq2lsu_w_ack = lsu2wbq_w_req & ~w_full & ~rst;
  assign w_push        = wbq2lsu_w_ack & (|lsu2wbq_rd_addr);
  // A load arriving alongside an ALU write to the same rd counts as older, so it is born stale.
  assign w_push_kill   = w_alu_take & (lsu2wbq_rd_addr == exu2wbq_rd_addr);

  always_comb begin
    w_src = WBQ_SRC_IDLE;
    if (w_alu_take) begin
      w_src = WBQ_SRC_ALU;
    end else if (!w_empty) begin
      w_src = w_head_kill ? WBQ_SRC_KILL : WBQ_SRC_LSU;
    end
  end

  assign w_pop = (w_src == WBQ_SRC_LSU) || (w_src == WBQ_SRC_KILL);

  scr1_pipe_wbq_fifo #(
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH),
    .XLEN  (XLEN)
  ) i_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_addr (lsu2wbq_rd_addr),
    .i_push_data (lsu2wbq_rd_data),
    .i_push_kill (w_push_kill),
    .i_pop       (w_pop),
    .i_kill_req  (w_alu_take),
    .i_kill_addr (exu2wbq_rd_addr),
    .i_rs1_addr  (exu2wbq_rs1_addr),
    .i_rs2_addr  (exu2wbq_rs2_addr),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_kill (w_head_kill),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_rs1_match (w_rs1_match),
    .o_rs2_match (w_rs2_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      unique case (w_src)
        WBQ_SRC_ALU: begin
          r_req  <= 1'b1;
          r_addr <= exu2wbq_rd_addr;
          r_data <= exu2wbq_rd_data;
        end
        WBQ_SRC_LSU: begin
          r_req  <= 1'b1;
          r_addr <= w_head_addr;
          r_data <= w_head_data;
        end
        default: r_req <= 1'b0;
      endcase
    end
  end

  assign wbq2mprf_w_req   = r_req;
  assign wbq2mprf_rd_addr = r_addr;
  assign wbq2mprf_rd_data = r_data;

  // The MPRF read port only sees a write after its edge, so the output register is still pending.
  assign wbq2exu_rs1_pend = (|exu2wbq_rs1_addr) &
                            ((|w_rs1_match) | (r_req & (r_addr == exu2wbq_rs1_addr)));
  assign wbq2exu_rs2_pend = (|exu2wbq_rs2_addr) &
                            ((|w_rs2_match) | (r_req & (r_addr == exu2wbq_rs2_addr)));

  assign wbq_empty = w_empty & ~r_req;

`ifdef SCR1_SIM_ENV
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(exu2wbq_w_req && $isunknown({exu2wbq_rd_addr, exu2wbq_rd_data})))
        else $error("wbq: X on ALU write");
      assert (!(lsu2wbq_w_req && $isunknown({lsu2wbq_rd_addr, lsu2wbq_rd_data})))
        else $error("wbq: X on load write");
      assert (!(wbq2mprf_w_req && $isunknown({wbq2mprf_rd_addr, wbq2mprf_rd_data})))
        else $error("wbq: X on MPRF write");
    end
  end
`endif

endmodule
